// File: rtl/alram_sdp_clr_pkg.sv
// rtl/alram_sdp_clr_pkg.sv - shared state encodings and lane-count helper for alram_sdp_clr
package alram_sdp_clr_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic int nbyte(input int wid, input int bytw);
    return wid / bytw;
  endfunction

endpackage

// File: rtl/alram_clrseq.sv
// rtl/alram_clrseq.sv - clear sweep FSM: walks every address once, writing the clear value
module alram_clrseq
  import alram_sdp_clr_pkg::*;
#(
  parameter int AWID       = 5,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  output logic            busy,
  output logic            clr_we,
  output logic [AWID-1:0] clr_a
);

  // Parking in CLEAR during reset makes busy follow CLR_ON_RST and starts the sweep at 0 on release.
  localparam logic [0:0] ST_RST = CLR_ON_RST ? ST_CLEAR : ST_IDLE;

  logic [0:0]      state_q, state_d;
  logic [AWID-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_IDLE) begin
      clr_cnt_d = '0;
      if (clr) begin
        state_d = ST_CLEAR;
      end
    end else begin
      if (clr_cnt_q == {AWID{1'b1}}) begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RST;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy   = (state_q == ST_CLEAR);
  assign clr_we = busy;
  assign clr_a  = clr_cnt_q;

endmodule

// File: rtl/alram_sdp_clr.sv
// rtl/alram_sdp_clr.sv - single-clock SDP RAM with byte enables, write-first forwarding and clear sweep
module alram_sdp_clr
  import alram_sdp_clr_pkg::*;
#(
  parameter int              WID        = 256,
  parameter int              BYTW       = 8,
  parameter int              AWID       = 5,
  parameter int              DEP        = 1 << AWID,
  parameter int              RLAT       = 1,
  parameter bit              CLR_ON_RST = 1'b1,
  parameter logic [WID-1:0]  CLRVAL     = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  output logic                 busy,
  input  logic                 we,
  input  logic [AWID-1:0]      wa,
  input  logic [WID-1:0]       wdi,
  input  logic [WID/BYTW-1:0]  wbe,
  input  logic                 re,
  input  logic [AWID-1:0]      ra,
  output logic [WID-1:0]       rdo,
  output logic                 rvld
);

  localparam int NBYTE = nbyte(WID, BYTW);

  if ((WID % BYTW) != 0 || (RLAT != 1 && RLAT != 2)) begin : g_bad_param
    $error("alram_sdp_clr: WID must be a multiple of BYTW and RLAT must be 1 or 2");
  end

  logic            clr_we;
  logic [AWID-1:0] clr_a;
  logic            wr_acc, rd_acc;

  alram_clrseq #(
    .AWID       (AWID),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clrseq (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .busy   (busy),
    .clr_we (clr_we),
    .clr_a  (clr_a)
  );

  assign wr_acc = we & ~busy;
  assign rd_acc = re & ~busy;

  logic [WID-1:0] mem [DEP];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_a] <= CLRVAL;
    end else if (wr_acc) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (wbe[i]) begin
          mem[wa][i*BYTW +: BYTW] <= wdi[i*BYTW +: BYTW];
        end
      end
    end
  end

  // Stage 1 captures the pre-write memory word plus the colliding write, merged on the way out.
  logic [WID-1:0]   rmem_q, rmem_d;
  logic             hit_q, hit_d;
  logic [WID-1:0]   fwd_di_q, fwd_di_d;
  logic [NBYTE-1:0] fwd_be_q, fwd_be_d;
  logic             v1_q, v1_d;
  logic [WID-1:0]   merged;

  always_comb begin
    rmem_d   = rmem_q;
    hit_d    = hit_q;
    fwd_di_d = fwd_di_q;
    fwd_be_d = fwd_be_q;
    v1_d     = rd_acc;
    if (rd_acc) begin
      rmem_d   = mem[ra];
      hit_d    = wr_acc && (wa == ra);
      fwd_di_d = wdi;
      fwd_be_d = wbe;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmem_q   <= '0;
      hit_q    <= 1'b0;
      fwd_di_q <= '0;
      fwd_be_q <= '0;
      v1_q     <= 1'b0;
    end else begin
      rmem_q   <= rmem_d;
      hit_q    <= hit_d;
      fwd_di_q <= fwd_di_d;
      fwd_be_q <= fwd_be_d;
      v1_q     <= v1_d;
    end
  end

  always_comb begin
    merged = rmem_q;
    for (int i = 0; i < NBYTE; i++) begin
      if (hit_q && fwd_be_q[i]) begin
        merged[i*BYTW +: BYTW] = fwd_di_q[i*BYTW +: BYTW];
      end
    end
  end

  if (RLAT == 2) begin : g_rlat2
    logic [WID-1:0] rdo2_q, rdo2_d;
    logic           rvld2_q, rvld2_d;

    always_comb begin
      rdo2_d  = v1_q ? merged : rdo2_q;
      rvld2_d = v1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdo2_q  <= '0;
        rvld2_q <= 1'b0;
      end else begin
        rdo2_q  <= rdo2_d;
        rvld2_q <= rvld2_d;
      end
    end

    assign rdo  = rdo2_q;
    assign rvld = rvld2_q;
  end else begin : g_rlat1
    assign rdo  = merged;
    assign rvld = v1_q;
  end

endmodule
